// File: rtl/uram_pkg.sv
// Shared definitions for the parametrised dual-port memory block.
// Contents:
//   RD_LAT_MIN / RD_LAT_MAX  legal read-latency range
//   num_lanes()              byte-lane count for a word/lane width pair
//   rd_stage_t               read-pipeline stage {valid, tag, data} at the
//                            default 72-bit word / 4-bit tag configuration
//   coll_policy_e            write/write collision resolution policy
package uram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  localparam int RD_STAGE_DATA_W = 72;
  localparam int RD_STAGE_TAG_W  = 4;

  function automatic int num_lanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  typedef struct packed {
    logic                       valid;
    logic [RD_STAGE_TAG_W-1:0]  tag;
    logic [RD_STAGE_DATA_W-1:0] data;
  } rd_stage_t;

  // Only port-A-wins exists today; the enum leaves room for other modes.
  typedef enum logic [0:0] {
    PORT_A_WINS = 1'b0
  } coll_policy_e;

endpackage

// File: rtl/uram_dp_pipe_if.sv
// One memory port: request bus (master drives) and read-return bus
// (slave drives).
//   req, we, addr, din, be, tag   request side
//   dout, rd_valid, rtag          read-return side
interface uram_dp_pipe_if
  import uram_pkg::*;
#(
  parameter int DATA_W = 72,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 12,
  parameter int TAG_W  = 4
);
  localparam int NUM_LANES = num_lanes(DATA_W, LANE_W);

  logic                 req;
  logic                 we;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    din;
  logic [NUM_LANES-1:0] be;
  logic [TAG_W-1:0]     tag;
  logic [DATA_W-1:0]    dout;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rtag;

  modport master (
    output req, we, addr, din, be, tag,
    input  dout, rd_valid, rtag
  );

  modport slave (
    input  req, we, addr, din, be, tag,
    output dout, rd_valid, rtag
  );
endinterface

// File: rtl/uram_rd_pipe.sv
// Read-return delay line for one port: STAGES register stages carrying
// {valid, tag, data}. Inner stages shift every cycle; the last stage only
// loads tag/data when a valid entry arrives so the outputs hold their last
// read result. STAGES = 0 is a straight wire.
//   clk, rst_async               clock, async active-high clear
//   valid_i, tag_i, data_i       stage-0 entry (array output register)
//   valid_o, tag_o, data_o       returned read
module uram_rd_pipe #(
  parameter int DATA_W = 72,
  parameter int TAG_W  = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              valid_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } stage_t;

  if (STAGES == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign tag_o   = tag_i;
    assign data_o  = data_i;
  end else begin : g_pipe
    stage_t stage_d [STAGES];
    stage_t stage_q [STAGES];

    always_comb begin
      stage_d[0] = {valid_i, tag_i, data_i};
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
        for (int i = 0; i < STAGES; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < STAGES; i++) begin
          stage_q[i].valid <= stage_d[i].valid;
          // Output stage loads only on a valid entry; it holds otherwise.
          if ((i != STAGES - 1) || stage_d[i].valid) begin
            stage_q[i].tag  <= stage_d[i].tag;
            stage_q[i].data <= stage_d[i].data;
          end
        end
      end
    end

    assign valid_o = stage_q[STAGES-1].valid;
    assign tag_o   = stage_q[STAGES-1].tag;
    assign data_o  = stage_q[STAGES-1].data;
  end

endmodule

// File: rtl/uram_dp_pipe.sv
// Parametrised true-dual-port memory with byte-lane writes, RD_LAT-cycle
// read pipeline, tag return and same-address collision handling.
//   clk        system clock
//   rst_async  asynchronous active-high reset (pipeline/outputs only)
//   port_a     port A bus (slave modport)
//   port_b     port B bus (slave modport)
//   coll_ab    one-cycle pulse after a write/write hit with overlapping lanes
// Reads are read-first against a same-cycle write from either port.
// Write/write on the same lane: port A wins.
module uram_dp_pipe
  import uram_pkg::*;
#(
  parameter int           DATA_W      = 72,
  parameter int           LANE_W      = 8,
  parameter int           ADDR_W      = 12,
  parameter int           RD_LAT      = 2,
  parameter int           TAG_W       = 4,
  parameter coll_policy_e COLL_POLICY = PORT_A_WINS
) (
  input  logic            clk,
  input  logic            rst_async,
  uram_dp_pipe_if.slave   port_a,
  uram_dp_pipe_if.slave   port_b,
  output logic            coll_ab
);

  localparam int NUM_LANES = num_lanes(DATA_W, LANE_W);
  localparam int DEPTH     = 2 ** ADDR_W;

  if ((DATA_W % LANE_W) != 0) begin : g_bad_lane_w
    $error("uram_dp_pipe: DATA_W must be a multiple of LANE_W");
  end
  if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
    $error("uram_dp_pipe: RD_LAT must be within 1..4");
  end
  if (COLL_POLICY != PORT_A_WINS) begin : g_bad_policy
    $error("uram_dp_pipe: unsupported collision policy");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_a, wr_b, rd_a, rd_b;
  logic coll_d, coll_q;

  assign wr_a = port_a.req &  port_a.we;
  assign wr_b = port_b.req &  port_b.we;
  assign rd_a = port_a.req & ~port_a.we;
  assign rd_b = port_b.req & ~port_b.we;

  assign coll_d = wr_a & wr_b & (port_a.addr == port_b.addr) &
                  ((port_a.be & port_b.be) != '0);

  // Port B is applied first so that port A's later assignment wins on
  // lanes both ports enable.
  always_ff @(posedge clk) begin
    if (wr_b) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (port_b.be[i]) begin
          mem_q[port_b.addr][i*LANE_W +: LANE_W] <= port_b.din[i*LANE_W +: LANE_W];
        end
      end
    end
    if (wr_a) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (port_a.be[i]) begin
          mem_q[port_a.addr][i*LANE_W +: LANE_W] <= port_a.din[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Stage 0: array output register. Sampling mem_q here sees the pre-write
  // contents, which gives read-first behaviour on a same-cycle write.
  // With RD_LAT = 1 this stage is the output, so tag/data hold between reads.
  logic              s0_valid_a_q, s0_valid_b_q;
  logic [TAG_W-1:0]  s0_tag_a_q,   s0_tag_b_q;
  logic [DATA_W-1:0] s0_data_a_q,  s0_data_b_q;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      s0_valid_a_q <= 1'b0;
      s0_tag_a_q   <= '0;
      s0_data_a_q  <= '0;
      s0_valid_b_q <= 1'b0;
      s0_tag_b_q   <= '0;
      s0_data_b_q  <= '0;
      coll_q       <= 1'b0;
    end else begin
      s0_valid_a_q <= rd_a;
      s0_valid_b_q <= rd_b;
      if (rd_a || (RD_LAT > 1)) begin
        s0_tag_a_q  <= port_a.tag;
        s0_data_a_q <= mem_q[port_a.addr];
      end
      if (rd_b || (RD_LAT > 1)) begin
        s0_tag_b_q  <= port_b.tag;
        s0_data_b_q <= mem_q[port_b.addr];
      end
      coll_q <= coll_d;
    end
  end

  assign coll_ab = coll_q;

  uram_rd_pipe #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .STAGES (RD_LAT - 1)
  ) u_pipe_a (
    .clk       (clk),
    .rst_async (rst_async),
    .valid_i   (s0_valid_a_q),
    .tag_i     (s0_tag_a_q),
    .data_i    (s0_data_a_q),
    .valid_o   (port_a.rd_valid),
    .tag_o     (port_a.rtag),
    .data_o    (port_a.dout)
  );

  uram_rd_pipe #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .STAGES (RD_LAT - 1)
  ) u_pipe_b (
    .clk       (clk),
    .rst_async (rst_async),
    .valid_i   (s0_valid_b_q),
    .tag_i     (s0_tag_b_q),
    .data_i    (s0_data_b_q),
    .valid_o   (port_b.rd_valid),
    .tag_o     (port_b.rtag),
    .data_o    (port_b.dout)
  );

endmodule

// File: tb/tb_uram_dp_pipe.sv
// Bench for uram_dp_pipe: one instance at RD_LAT=2 (both ports) and one at
// RD_LAT=4 (port A streaming). A behavioural memory model produces the
// expected read results, which are queued with their due cycle and popped
// by a monitor when the DUT returns data.
module tb_uram_dp_pipe;

  localparam int DW = 72;
  localparam int AW = 12;
  localparam int TW = 4;
  localparam int NL = 9;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coll2, coll4;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   v4_cnt = 0;

  exp_t          q2a[$], q2b[$], q4a[$];
  logic [DW-1:0] m2 [int];
  logic [DW-1:0] m4 [int];
  bit            coll_exp [int];

  uram_dp_pipe_if #(.DATA_W(DW), .LANE_W(8), .ADDR_W(AW), .TAG_W(TW)) a2 ();
  uram_dp_pipe_if #(.DATA_W(DW), .LANE_W(8), .ADDR_W(AW), .TAG_W(TW)) b2 ();
  uram_dp_pipe_if #(.DATA_W(DW), .LANE_W(8), .ADDR_W(AW), .TAG_W(TW)) a4 ();
  uram_dp_pipe_if #(.DATA_W(DW), .LANE_W(8), .ADDR_W(AW), .TAG_W(TW)) b4 ();

  uram_dp_pipe #(.DATA_W(DW), .LANE_W(8), .ADDR_W(AW), .RD_LAT(2), .TAG_W(TW)) dut2 (
    .clk(clk), .rst_async(rst), .port_a(a2), .port_b(b2), .coll_ab(coll2));

  uram_dp_pipe #(.DATA_W(DW), .LANE_W(8), .ADDR_W(AW), .RD_LAT(4), .TAG_W(TW)) dut4 (
    .clk(clk), .rst_async(rst), .port_a(a4), .port_b(b4), .coll_ab(coll4));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Monitor: read returns and collision pulses, sampled on the falling edge.
  initial forever begin
    exp_t e;
    bit   ce;
    @(negedge clk);
    if (a2.rd_valid) begin
      checks++;
      if (q2a.size() == 0) $display("FAIL a2_unexpected_valid: got rd_valid=1 at cyc %0d, want 0", cyc);
      else begin
        e = q2a.pop_front();
        if (a2.dout !== e.data || a2.rtag !== e.tag || e.due != cyc)
          $display("FAIL a2_read: got data=%h tag=%0d cyc=%0d, want data=%h tag=%0d cyc=%0d",
                   a2.dout, a2.rtag, cyc, e.data, e.tag, e.due);
        else passed++;
      end
    end else if (q2a.size() > 0 && q2a[0].due <= cyc) begin
      checks++;
      $display("FAIL a2_missing_valid: got rd_valid=0 at cyc %0d, want 1 (tag %0d)", cyc, q2a[0].tag);
      void'(q2a.pop_front());
    end
    if (b2.rd_valid) begin
      checks++;
      if (q2b.size() == 0) $display("FAIL b2_unexpected_valid: got rd_valid=1 at cyc %0d, want 0", cyc);
      else begin
        e = q2b.pop_front();
        if (b2.dout !== e.data || b2.rtag !== e.tag || e.due != cyc)
          $display("FAIL b2_read: got data=%h tag=%0d cyc=%0d, want data=%h tag=%0d cyc=%0d",
                   b2.dout, b2.rtag, cyc, e.data, e.tag, e.due);
        else passed++;
      end
    end else if (q2b.size() > 0 && q2b[0].due <= cyc) begin
      checks++;
      $display("FAIL b2_missing_valid: got rd_valid=0 at cyc %0d, want 1 (tag %0d)", cyc, q2b[0].tag);
      void'(q2b.pop_front());
    end
    if (a4.rd_valid) begin
      checks++;
      v4_cnt++;
      if (q4a.size() == 0) $display("FAIL a4_unexpected_valid: got rd_valid=1 at cyc %0d, want 0", cyc);
      else begin
        e = q4a.pop_front();
        if (a4.dout !== e.data || a4.rtag !== e.tag || e.due != cyc)
          $display("FAIL a4_read: got data=%h tag=%0d cyc=%0d, want data=%h tag=%0d cyc=%0d",
                   a4.dout, a4.rtag, cyc, e.data, e.tag, e.due);
        else passed++;
      end
    end else if (q4a.size() > 0 && q4a[0].due <= cyc) begin
      checks++;
      $display("FAIL a4_missing_valid: got rd_valid=0 at cyc %0d, want 1 (tag %0d)", cyc, q4a[0].tag);
      void'(q4a.pop_front());
    end
    ce = coll_exp.exists(cyc) ? coll_exp[cyc] : 1'b0;
    if (coll2 !== ce) begin
      checks++;
      $display("FAIL coll_ab: got %b at cyc %0d, want %b", coll2, cyc, ce);
    end else if (ce) begin
      checks++;
      passed++;
    end
  end

  task automatic idle_all();
    a2.req = 0; a2.we = 0; b2.req = 0; b2.we = 0;
    a4.req = 0; a4.we = 0; b4.req = 0; b4.we = 0;
  endtask

  task automatic drv_a2(input bit we, input int addr, input logic [DW-1:0] din,
                        input logic [NL-1:0] be, input int tag);
    a2.req = 1; a2.we = we; a2.addr = AW'(addr); a2.din = din; a2.be = be; a2.tag = TW'(tag);
  endtask

  task automatic drv_b2(input bit we, input int addr, input logic [DW-1:0] din,
                        input logic [NL-1:0] be, input int tag);
    b2.req = 1; b2.we = we; b2.addr = AW'(addr); b2.din = din; b2.be = be; b2.tag = TW'(tag);
  endtask

  task automatic drv_a4(input bit we, input int addr, input logic [DW-1:0] din,
                        input logic [NL-1:0] be, input int tag);
    a4.req = 1; a4.we = we; a4.addr = AW'(addr); a4.din = din; a4.be = be; a4.tag = TW'(tag);
  endtask

  // Consume the inputs currently driven: queue expected reads (model read
  // before model write = read-first), update the model, advance one cycle.
  task automatic tick();
    exp_t          e;
    logic [DW-1:0] w;
    int            k;
    if (a2.req && !a2.we) begin
      k = int'(a2.addr);
      e.tag = a2.tag; e.data = m2.exists(k) ? m2[k] : 'x; e.due = cyc + 2;
      q2a.push_back(e);
    end
    if (b2.req && !b2.we) begin
      k = int'(b2.addr);
      e.tag = b2.tag; e.data = m2.exists(k) ? m2[k] : 'x; e.due = cyc + 2;
      q2b.push_back(e);
    end
    if (a4.req && !a4.we) begin
      k = int'(a4.addr);
      e.tag = a4.tag; e.data = m4.exists(k) ? m4[k] : 'x; e.due = cyc + 4;
      q4a.push_back(e);
    end
    coll_exp[cyc+1] = a2.req && a2.we && b2.req && b2.we &&
                      (a2.addr == b2.addr) && ((a2.be & b2.be) != '0);
    if (b2.req && b2.we) begin
      k = int'(b2.addr);
      w = m2.exists(k) ? m2[k] : '0;
      for (int i = 0; i < NL; i++) if (b2.be[i]) w[i*8 +: 8] = b2.din[i*8 +: 8];
      m2[k] = w;
    end
    if (a2.req && a2.we) begin
      k = int'(a2.addr);
      w = m2.exists(k) ? m2[k] : '0;
      for (int i = 0; i < NL; i++) if (a2.be[i]) w[i*8 +: 8] = a2.din[i*8 +: 8];
      m2[k] = w;
    end
    if (a4.req && a4.we) begin
      k = int'(a4.addr);
      w = m4.exists(k) ? m4[k] : '0;
      for (int i = 0; i < NL; i++) if (a4.be[i]) w[i*8 +: 8] = a4.din[i*8 +: 8];
      m4[k] = w;
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_reset();
    idle_all();
    a2.addr = '0; a2.din = '0; a2.be = '0; a2.tag = '0;
    b2.addr = '0; b2.din = '0; b2.be = '0; b2.tag = '0;
    a4.addr = '0; a4.din = '0; a4.be = '0; a4.tag = '0;
    b4.addr = '0; b4.din = '0; b4.be = '0; b4.tag = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (a2.rd_valid !== 0 || b2.rd_valid !== 0 || a4.rd_valid !== 0 || coll2 !== 0)
      $display("FAIL reset_valid: got a2=%b b2=%b a4=%b coll=%b, want all 0", a2.rd_valid, b2.rd_valid, a4.rd_valid, coll2);
    else passed++;
    checks++;
    if (a2.dout !== '0 || b2.dout !== '0 || a2.rtag !== '0 || b2.rtag !== '0)
      $display("FAIL reset_data: got dout_a=%h dout_b=%h rtag_a=%0d rtag_b=%0d, want 0", a2.dout, b2.dout, a2.rtag, b2.rtag);
    else passed++;
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    drv_a2(1, 5, 72'h0123456789ABCDEF01, 9'h1FF, 0);
    tick();
    tick();
    drv_b2(0, 5, '0, '0, 3);
    tick();
    checks++;
    if (b2.rd_valid !== 0) $display("FAIL wr_rd_early: got rd_valid_b=%b one cycle after read, want 0", b2.rd_valid);
    else passed++;
    tick();
    checks++;
    if (b2.rd_valid !== 1 || b2.dout !== 72'h0123456789ABCDEF01 || b2.rtag !== 4'd3)
      $display("FAIL wr_rd_result: got valid=%b dout=%h rtag=%0d, want 1 0123456789abcdef01 3", b2.rd_valid, b2.dout, b2.rtag);
    else passed++;
    tick();
    checks++;
    if (b2.rd_valid !== 0 || b2.dout !== 72'h0123456789ABCDEF01)
      $display("FAIL wr_rd_hold: got valid=%b dout=%h, want 0 and held data", b2.rd_valid, b2.dout);
    else passed++;
  endtask

  task automatic test_ww_collision();
    drv_a2(1, 7, {DW{1'b1}}, 9'h00F, 0);
    drv_b2(1, 7, '0, 9'h1F8, 0);
    tick();
    checks++;
    if (coll2 !== 1) $display("FAIL ww_coll_pulse: got coll_ab=%b, want 1", coll2);
    else passed++;
    tick();
    checks++;
    if (coll2 !== 0) $display("FAIL ww_coll_width: got coll_ab=%b, want 0", coll2);
    else passed++;
    drv_a2(0, 7, '0, '0, 6);
    tick();
    tick();
    checks++;
    if (a2.rd_valid !== 1 || a2.dout !== 72'h0000000000FFFFFFFF)
      $display("FAIL ww_merge: got valid=%b dout=%h, want 1 0000000000ffffffff", a2.rd_valid, a2.dout);
    else passed++;
    drv_a2(1, 7, {DW{1'b1}}, 9'h001, 0);
    drv_b2(1, 7, '0, 9'h002, 0);
    tick();
    checks++;
    if (coll2 !== 0) $display("FAIL ww_no_overlap: got coll_ab=%b, want 0", coll2);
    else passed++;
    drv_a2(0, 7, '0, '0, 2);
    tick();
    tick();
    checks++;
    if (a2.dout !== 72'h0000000000FFFF00FF)
      $display("FAIL ww_disjoint_merge: got dout=%h, want 0000000000ffff00ff", a2.dout);
    else passed++;
  endtask

  task automatic test_rw_collision();
    drv_a2(1, 9, 72'h11, 9'h1FF, 0);
    tick();
    drv_a2(1, 9, 72'h22, 9'h1FF, 0);
    drv_b2(0, 9, '0, '0, 5);
    tick();
    tick();
    checks++;
    if (b2.rd_valid !== 1 || b2.dout !== 72'h11 || b2.rtag !== 4'd5)
      $display("FAIL rw_read_first: got valid=%b dout=%h rtag=%0d, want 1 11 5", b2.rd_valid, b2.dout, b2.rtag);
    else passed++;
    drv_a2(0, 9, '0, '0, 8);
    drv_b2(0, 9, '0, '0, 9);
    tick();
    tick();
    checks++;
    if (a2.dout !== 72'h22 || b2.dout !== 72'h22 || a2.rtag !== 4'd8 || b2.rtag !== 4'd9 || coll2 !== 0)
      $display("FAIL rr_same_addr: got a=%h/%0d b=%h/%0d coll=%b, want 22/8 22/9 0", a2.dout, a2.rtag, b2.dout, b2.rtag, coll2);
    else passed++;
  endtask

  task automatic test_partial_write();
    drv_b2(1, 12, '0, 9'h1FF, 0);
    tick();
    drv_b2(1, 12, {64'hCCCC_CCCC_CCCC_CCCC, 8'hAB}, 9'h001, 0);
    tick();
    drv_b2(1, 12, {DW{1'b1}}, 9'h000, 0);
    tick();
    drv_b2(0, 12, '0, '0, 1);
    tick();
    tick();
    checks++;
    if (b2.rd_valid !== 1 || b2.dout !== 72'h0000000000000000AB)
      $display("FAIL partial_write: got valid=%b dout=%h, want 1 0000000000000000ab", b2.rd_valid, b2.dout);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int base;
    for (int i = 0; i < 8; i++) begin
      drv_a4(1, 'h40 + i, {8'($urandom), $urandom, $urandom}, 9'h1FF, 0);
      tick();
    end
    base = v4_cnt;
    for (int i = 0; i < 8; i++) begin
      drv_a4(0, 'h40 + i, '0, '0, i);
      tick();
    end
    repeat (5) tick();
    checks++;
    if (v4_cnt - base != 8) $display("FAIL b2b_count: got %0d rd_valid_a cycles, want 8", v4_cnt - base);
    else passed++;
    checks++;
    if (a4.rtag !== 4'd7) $display("FAIL b2b_last_tag: got rtag=%0d, want 7", a4.rtag);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    drv_a2(0, 5, '0, '0, 1);
    tick();
    drv_a2(0, 7, '0, '0, 2);
    tick();
    drv_a2(0, 9, '0, '0, 3);
    tick();
    tick();
    #2;
    rst = 1;
    q2a.delete();
    q2b.delete();
    #1;
    checks++;
    if (a2.rd_valid !== 0 || a2.dout !== '0 || a2.rtag !== '0)
      $display("FAIL rst_assert: got valid=%b dout=%h rtag=%0d, want 0 0 0", a2.rd_valid, a2.dout, a2.rtag);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (5) begin
      tick();
      checks++;
      if (a2.rd_valid !== 0 || a2.dout !== '0)
        $display("FAIL rst_discard: got valid=%b dout=%h at cyc %0d, want 0 0", a2.rd_valid, a2.dout, cyc);
      else passed++;
    end
  endtask

  task automatic test_drain();
    repeat (6) tick();
    checks++;
    if (q2a.size() + q2b.size() + q4a.size() != 0)
      $display("FAIL drain: got %0d reads outstanding, want 0", q2a.size() + q2b.size() + q4a.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ww_collision();
    test_rw_collision();
    test_partial_write();
    test_back_to_back();
    test_reset_midflight();
    test_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
